// File: rtl/numpad_scan.sv
// numpad_scan: scans a 4x4 active-low key matrix plus an alt key, debounces both
// once per full scan, and presents one key event per debounced press on valid/ready.
module numpad_scan #(
   parameter int COL_DWELL      = 256,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] numpad_rows,
   input  logic       alt_numpad_key,
   output logic [3:0] numpad_columns,
   output logic       alt_numpad_led,
   output logic       key_valid,
   output logic [4:0] key_code,
   output logic       key_alt,
   input  logic       key_ready
);
   localparam int            DW         = $clog2(COL_DWELL);
   localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
   localparam logic [3:0]    DB_MAX     = 4'(DEBOUNCE_SCANS);
   localparam logic [4:0]    NONE       = 5'b00000;

   typedef enum logic {IDLE, PENDING} hs_state_t;
   hs_state_t state, state_next;

   logic [3:0]    rows_s1, rows_s2;
   logic          alt_s1, alt_s2, alt_lvl;
   logic [1:0]    col;
   logic [DW-1:0] dwell;
   logic          sample, scan_end;
   logic [3:0]    row_low;
   logic [1:0]    row_idx;
   logic [4:0]    hit_code, found_code, result;
   logic          found;
   logic [4:0]    key_cand, key_acc;
   logic [3:0]    key_cnt, key_cnt_next;
   logic          key_take, key_fire;
   logic          alt_cand, alt_acc;
   logic [3:0]    alt_cnt, alt_cnt_next;
   logic          alt_take, alt_toggle;
   logic          alt_armed, alt_armed_next;
   logic          accept, load;

   always_ff @(posedge clock) begin
      if (reset) begin
         rows_s1 <= 4'hF;
         rows_s2 <= 4'hF;
         alt_s1  <= 1'b1;
         alt_s2  <= 1'b1;
      end else begin
         rows_s1 <= numpad_rows;
         rows_s2 <= rows_s1;
         alt_s1  <= alt_numpad_key;
         alt_s2  <= alt_s1;
      end
   end

   assign sample         = (dwell == DWELL_LAST);
   assign scan_end       = sample && (col == 2'd3);
   assign numpad_columns = ~(4'b0001 << col);

   always_ff @(posedge clock) begin
      if (reset) begin
         col   <= 2'd0;
         dwell <= '0;
      end else if (sample) begin
         col   <= col + 2'd1;
         dwell <= '0;
      end else begin
         dwell <= dwell + DW'(1);
      end
   end

   // Lowest pressed row in the driven column; earlier columns already latched take priority.
   always_comb begin
      row_low = ~rows_s2;
      row_idx = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (row_low[r]) row_idx = 2'(r);
      end
      hit_code = (row_low != 4'b0000) ? {1'b1, col, row_idx} : NONE;
      result   = found ? found_code : hit_code;
   end

   always_ff @(posedge clock) begin
      if (reset || scan_end) begin
         found      <= 1'b0;
         found_code <= NONE;
      end else if (sample && !found && (hit_code != NONE)) begin
         found      <= 1'b1;
         found_code <= hit_code;
      end
   end

   always_comb begin
      alt_lvl      = ~alt_s2;
      key_cnt_next = (result != key_cand) ? 4'd1 :
                     (key_cnt >= DB_MAX)  ? DB_MAX : key_cnt + 4'd1;
      alt_cnt_next = (alt_lvl != alt_cand) ? 4'd1 :
                     (alt_cnt >= DB_MAX)   ? DB_MAX : alt_cnt + 4'd1;
      key_take     = (key_cnt_next == DB_MAX) && (result != key_acc);
      alt_take     = (alt_cnt_next == DB_MAX) && (alt_lvl != alt_acc);
      key_fire     = scan_end && key_take && (result != NONE);
      alt_toggle   = scan_end && alt_take && alt_lvl;
      accept       = key_valid && key_ready;
      // Toggle first so an event at the same scan end carries the new alt state.
      alt_armed_next = alt_armed ^ alt_toggle;
      if (accept && key_alt) alt_armed_next = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         key_cand  <= NONE;
         key_acc   <= NONE;
         key_cnt   <= 4'd0;
         alt_cand  <= 1'b0;
         alt_acc   <= 1'b0;
         alt_cnt   <= 4'd0;
         alt_armed <= 1'b0;
      end else begin
         alt_armed <= alt_armed_next;
         if (scan_end) begin
            key_cand <= result;
            key_cnt  <= key_cnt_next;
            alt_cand <= alt_lvl;
            alt_cnt  <= alt_cnt_next;
            if (key_take) key_acc <= result;
            if (alt_take) alt_acc <= alt_lvl;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // A press arriving while an event is pending is dropped.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE:    if (key_fire) begin
                     state_next = PENDING;
                     load       = 1'b1;
                  end
         PENDING: if (key_ready) state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         key_code <= NONE;
         key_alt  <= 1'b0;
      end else if (load) begin
         key_code <= result;
         key_alt  <= alt_armed_next;
      end else if (accept) begin
         key_code <= NONE;
         key_alt  <= 1'b0;
      end
   end

   assign key_valid      = (state == PENDING);
   assign alt_numpad_led = ~alt_armed;

endmodule
